// File: rtl/vip_maxpool_pkg.sv
// Shared types, default map geometry and the ReLU helper for the ReLU + 2x2 max-pool stage.
// Optional ReLU is enabled by defining VIP_MAXPOOL_RELU_EN.
package vip_maxpool_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam int DEF_WIDTH  = 112;
   localparam int DEF_HEIGHT = 112;

   // Any word with the sign bit set (negatives and -0) becomes +0.
   function automatic logic [31:0] relu(input logic [31:0] x);
      return x[31] ? 32'h0000_0000 : x;
   endfunction

endpackage

// File: rtl/vip_fp32_max.sv
// Combinational two-operand fp32 max; on a tie the a operand (left/upper) is returned.
// VIP_MAXPOOL_RELU_EN selects the non-negative magnitude compare, otherwise IEEE-754 ordering.
module vip_fp32_max (
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] y
);

`ifdef VIP_MAXPOOL_RELU_EN
   // Operands are already ReLU'd, so magnitude order equals value order.
   always_comb begin
      y = a;
      if (b[30:0] > a[30:0]) y = b;
   end
`else
   always_comb begin
      y = a;
      if ((a[30:0] == 31'd0) && (b[30:0] == 31'd0)) begin
         y = a;
      end else if (a[31] != b[31]) begin
         y = a[31] ? b : a;
      end else if (!a[31]) begin
         if (b[30:0] > a[30:0]) y = b;
      end else begin
         if (b[30:0] < a[30:0]) y = b;
      end
   end
`endif

endmodule

// File: rtl/core_featuremap_relu_maxpool2x2.sv
// Drains raster fp32 pixels from the conv FIFO, applies optional ReLU and 2x2 stride-2 max pooling.
// ReLU is applied only when VIP_MAXPOOL_RELU_EN is defined; maps stream back-to-back.
module core_featuremap_relu_maxpool2x2
   import vip_maxpool_pkg::*;
#(
   parameter int DWIDTH = 32,
   parameter int WIDTH  = DEF_WIDTH,
   parameter int HEIGHT = DEF_HEIGHT
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [DWIDTH-1:0] ff_rdata,
   output logic              ff_rdreq,
   input  logic              ff_empty,
   output logic [DWIDTH-1:0] ff_wdata,
   output logic              ff_wrreq,
   input  logic              ff_full,
   output logic              map_done,
   output state_t            fsm_state
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam int RW = (HEIGHT > 2) ? $clog2(HEIGHT) : 1;
   localparam int LW = (CW > 1) ? CW - 1 : 1;

   state_t            state, state_nxt;
   logic              rd_vld;
   logic [CW-1:0]     col;
   logic [RW-1:0]     row;
   logic [31:0]       h;
   logic [31:0]       pix;
   logic [31:0]       hmax;
   logic [31:0]       vmax;
   logic [LW-1:0]     lb_idx;
   logic              col_last;
   logic              row_last;
   logic [31:0]       linebuf [WIDTH/2];

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    state_nxt = RUN;
         RUN:     state_nxt = RUN;
         default: state_nxt = IDLE;
      endcase
   end

   assign fsm_state = state;

   // Read handshake: ff_rdreq pops one word from a non-show-ahead FIFO; rd_vld marks the
   // following cycle, when ff_rdata holds that word. At most one read is ever in flight.
   assign ff_rdreq = (state == RUN) && !ff_empty && !ff_full;

`ifdef VIP_MAXPOOL_RELU_EN
   assign pix = relu(ff_rdata);
`else
   assign pix = ff_rdata;
`endif

   assign lb_idx   = LW'(col >> 1);
   assign col_last = (col == CW'(WIDTH - 1));
   assign row_last = (row == RW'(HEIGHT - 1));

   vip_fp32_max u_hmax (
      .a (h),
      .b (pix),
      .y (hmax)
   );

   vip_fp32_max u_vmax (
      .a (linebuf[lb_idx]),
      .b (hmax),
      .y (vmax)
   );

   always_ff @(posedge clock) begin
      if (!reset) begin
         state    <= IDLE;
         rd_vld   <= 1'b0;
         col      <= '0;
         row      <= '0;
         h        <= '0;
         ff_wdata <= '0;
         ff_wrreq <= 1'b0;
         map_done <= 1'b0;
      end else begin
         state    <= state_nxt;
         rd_vld   <= ff_rdreq;
         ff_wrreq <= 1'b0;
         map_done <= 1'b0;
         if (rd_vld) begin
            if (!col[0]) begin
               h <= pix;
            end else if (row[0]) begin
               ff_wdata <= vmax;
               ff_wrreq <= 1'b1;
               map_done <= col_last && row_last;
            end
            if (col_last) begin
               col <= '0;
               row <= row_last ? '0 : row + 1'b1;
            end else begin
               col <= col + 1'b1;
            end
         end
      end
   end

   // No reset on the line buffer so it maps onto RAM; even rows always fill it before odd rows read.
   always_ff @(posedge clock) begin
      if (reset && rd_vld && col[0] && !row[0]) begin
         linebuf[lb_idx] <= hmax;
      end
   end

endmodule

// File: tb/tb_core_featuremap_relu_maxpool2x2.sv
// Directed bench for the ReLU + 2x2 max-pool stage on a 4x4 map, FIFO models on both sides.
// Expected values follow VIP_MAXPOOL_RELU_EN when it is defined for the build.
module tb_core_featuremap_relu_maxpool2x2;
   import vip_maxpool_pkg::*;

   localparam int W = 4;
   localparam int H = 4;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] ff_rdata = 32'h0;
   logic        ff_rdreq;
   logic        ff_empty = 1'b1;
   logic [31:0] ff_wdata;
   logic        ff_wrreq;
   logic        ff_full = 1'b0;
   logic        map_done;
   state_t      fsm_state;

   logic [31:0] src_q[$];
   logic [31:0] exp_q[$];
   int          rd_cyc_q[$];
   int          cyc = 0;
   int          rd_n = 0;
   int          wr_n = 0;
   int          wr_total = 0;
   int          exp_total = 0;
   int          viol = 0;
   int          n_checks = 0;
   int          n_err = 0;
   bit          stall_en = 1'b0;
   bit          full_force = 1'b0;

   core_featuremap_relu_maxpool2x2 #(.DWIDTH(32), .WIDTH(W), .HEIGHT(H)) dut (
      .clock     (clock),
      .reset     (reset),
      .ff_rdata  (ff_rdata),
      .ff_rdreq  (ff_rdreq),
      .ff_empty  (ff_empty),
      .ff_wdata  (ff_wdata),
      .ff_wrreq  (ff_wrreq),
      .ff_full   (ff_full),
      .map_done  (map_done),
      .fsm_state (fsm_state)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Upstream FIFO model: non-show-ahead, data one cycle after the pop.
   always @(posedge clock) begin
      if (ff_rdreq && (src_q.size() > 0)) ff_rdata <= src_q.pop_front();
   end

   always @(negedge clock) begin
      #1;
      ff_empty = (src_q.size() == 0) || (stall_en && ($urandom_range(0, 3) == 0));
      ff_full  = full_force || (stall_en && ($urandom_range(0, 4) == 0));
   end

   always @(negedge clock) begin
      int k, pix;
      #2;
      if (!reset) begin
         rd_cyc_q.delete();
         rd_n = 0;
         wr_n = 0;
      end else begin
         if (ff_rdreq) begin
            rd_cyc_q.push_back(cyc);
            rd_n++;
            if (ff_empty || ff_full) viol++;
         end
         if (ff_wrreq) begin
            wr_total++;
            if (exp_q.size() == 0) check("extra_write", 32'd1, 32'd0);
            else                   check("wdata", ff_wdata, exp_q.pop_front());
            check("map_done", {31'd0, map_done}, ((wr_n % 4) == 3) ? 32'd1 : 32'd0);
            k   = wr_n % 4;
            pix = (wr_n / 4) * 16 + (2 * (k / 2) + 1) * W + 2 * (k % 2) + 1;
            if (pix < rd_cyc_q.size()) check("latency", cyc - rd_cyc_q[pix], 32'd2);
            else                       check("latency_no_read", 32'd1, 32'd0);
            wr_n++;
         end else if (map_done) begin
            check("done_stray", 32'd1, 32'd0);
         end
      end
   end

   function automatic longint key(input logic [31:0] x);
      longint m;
      m = longint'(x[30:0]);
      return x[31] ? -m : m;
   endfunction

   function automatic logic [31:0] gmax(input logic [31:0] a, input logic [31:0] b);
      return (key(b) > key(a)) ? b : a;
   endfunction

   function automatic logic [31:0] act(input logic [31:0] x);
`ifdef VIP_MAXPOOL_RELU_EN
      if (x[31]) return 32'h0;
`endif
      return x;
   endfunction

   task automatic push_rand_map();
      logic [31:0] px[16];
      logic        s;
      logic [7:0]  e;
      logic [22:0] f;
      int          b;
      for (int i = 0; i < 16; i++) begin
         s = 1'($urandom_range(0, 1));
         e = 8'($urandom_range(100, 150));
         f = 23'($urandom);
         px[i] = {s, e, f};
         src_q.push_back(px[i]);
      end
      for (int wr = 0; wr < 2; wr++) begin
         for (int wc = 0; wc < 2; wc++) begin
            b = 2 * wr * W + 2 * wc;
            exp_q.push_back(gmax(gmax(act(px[b]), act(px[b+1])),
                                 gmax(act(px[b+W]), act(px[b+W+1]))));
            exp_total++;
         end
      end
   endtask

   task automatic wait_writes();
      int budget;
      budget = 4000;
      while ((wr_total < exp_total) && (budget > 0)) begin
         @(negedge clock);
         budget--;
      end
      if (budget == 0) check("write_timeout", wr_total, exp_total);
      repeat (4) @(negedge clock);
      check("exp_drained", exp_q.size(), 32'd0);
   endtask

   task automatic wait_reads(input int target);
      int budget;
      budget = 1000;
      while ((rd_n < target) && (budget > 0)) begin
         @(negedge clock);
         budget--;
      end
      if (budget == 0) check("read_timeout", rd_n, target);
   endtask

   initial begin
      logic [31:0] m1[16];
      logic [31:0] m2[16];
      logic [31:0] e2[4];
      int          saved_wr, saved_rd, base;

      m1 = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
             32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000,
             32'h41100000, 32'h41200000, 32'h41300000, 32'h41400000,
             32'h41500000, 32'h41600000, 32'h41700000, 32'h41800000};
      m2 = '{32'hC0400000, 32'h80000000, 32'hC0400000, 32'hC0000000,
             32'hBF800000, 32'hC0000000, 32'hC0A00000, 32'hC0800000,
             32'h00000000, 32'h80000000, 32'hC0F00000, 32'h40200000,
             32'h80000000, 32'h00000000, 32'h40400000, 32'hBF800000};
`ifdef VIP_MAXPOOL_RELU_EN
      e2 = '{32'h00000000, 32'h00000000, 32'h00000000, 32'h40400000};
`else
      e2 = '{32'h80000000, 32'hC0000000, 32'h00000000, 32'h40400000};
`endif

      // Reset state, with data already waiting upstream.
      repeat (3) @(negedge clock);
      for (int i = 0; i < 16; i++) src_q.push_back(m1[i]);
      exp_q.push_back(32'h40C00000);
      exp_q.push_back(32'h41000000);
      exp_q.push_back(32'h41600000);
      exp_q.push_back(32'h41800000);
      exp_total += 4;
      #3;
      check("rst_rdreq", {31'd0, ff_rdreq}, 32'd0);
      check("rst_wrreq", {31'd0, ff_wrreq}, 32'd0);
      check("rst_wdata", ff_wdata, 32'd0);
      check("rst_map_done", {31'd0, map_done}, 32'd0);
      check("rst_state", 32'(fsm_state), 32'(IDLE));

      @(negedge clock);
      reset = 1'b1;
      #3;
      check("idle_state", 32'(fsm_state), 32'(IDLE));
      check("idle_rdreq", {31'd0, ff_rdreq}, 32'd0);
      @(negedge clock);
      #3;
      check("run_state", 32'(fsm_state), 32'(RUN));
      check("first_rdreq", {31'd0, ff_rdreq}, 32'd1);
      wait_writes();

      // Signed and zero windows.
      for (int i = 0; i < 16; i++) src_q.push_back(m2[i]);
      for (int i = 0; i < 4; i++) exp_q.push_back(e2[i]);
      exp_total += 4;
      wait_writes();

      // Back-to-back maps under random empty/full stalls.
      stall_en = 1'b1;
      for (int i = 0; i < 6; i++) push_rand_map();
      wait_writes();
      stall_en = 1'b0;
      repeat (3) @(negedge clock);

      // Reset mid-map: the partial map must produce nothing.
      base = rd_n;
      for (int i = 0; i < 5; i++) src_q.push_back(32'h40000000 + 32'(i));
      wait_reads(base + 5);
      reset = 1'b0;
      src_q.delete();
      saved_wr = wr_total;
      repeat (2) @(negedge clock);
      #3;
      check("mid_rst_wrreq", {31'd0, ff_wrreq}, 32'd0);
      @(negedge clock);
      reset = 1'b1;
      check("mid_rst_nowrite", wr_total, saved_wr);
      push_rand_map();
      wait_writes();

      // Downstream almost-full held mid-row.
      base = rd_n;
      push_rand_map();
      wait_reads(base + 6);
      full_force = 1'b1;
      saved_wr = wr_total;
      saved_rd = rd_n;
      repeat (100) @(negedge clock);
      check("hold_writes_le1", ((wr_total - saved_wr) <= 1) ? 32'd1 : 32'd0, 32'd1);
      check("hold_no_read", rd_n, saved_rd);
      full_force = 1'b0;
      wait_writes();

      check("rdreq_gate_violations", viol, 32'd0);
      check("total_writes", wr_total, exp_total);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
